// File: rtl/bit32_demux1to3_reg_if.sv
// Bus bundle for the registered 1-to-3 demux: one valid/ready source side,
// three valid/ready sink sides and the illegal-select pulse.
interface bit32_demux1to3_reg_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic             out_valid0, out_valid1, out_valid2;
  logic             out_ready0, out_ready1, out_ready2;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2;
  logic             sel_err;

  modport master (
    output in_valid, in_sel, in_data, out_ready0, out_ready1, out_ready2,
    input  in_ready, out_valid0, out_valid1, out_valid2,
           out_data0, out_data1, out_data2, sel_err
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready0, out_ready1, out_ready2,
    output in_ready, out_valid0, out_valid1, out_valid2,
           out_data0, out_data1, out_data2, sel_err
  );
endinterface

// File: rtl/bit32_demux1to3_reg.sv
// Registered 1-to-3 valid/ready demux with a one-entry output register per channel.
// Optional per-channel accept counters when DEMUX_CNT_EN is defined.
module bit32_demux1to3_reg_lane #(
  parameter int WIDTH = 32
`ifdef DEMUX_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc,
  input  logic [WIDTH-1:0] din,
  input  logic             oready,
  output logic             ovalid,
  output logic [WIDTH-1:0] odata
`ifdef DEMUX_CNT_EN
  , output logic [CNT_W-1:0] cnt
`endif
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0] state;

  // Accept is only possible when empty or draining, so accept wins over drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      odata <= '0;
    end else if (acc) begin
      state <= FULL;
      odata <= din;
    end else if (oready) begin
      state <= EMPTY;
    end
  end

  assign ovalid = (state == FULL);

`ifdef DEMUX_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (acc) cnt <= cnt + 1'b1;
  end
`endif
endmodule

module bit32_demux1to3_reg #(
  parameter int WIDTH = 32
`ifdef DEMUX_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bit32_demux1to3_reg_if.slave   bus
`ifdef DEMUX_CNT_EN
  , output logic [CNT_W-1:0]     cnt0,
  output logic [CNT_W-1:0]       cnt1,
  output logic [CNT_W-1:0]       cnt2
`endif
);
  localparam int         NUM_LANES = 3;
  localparam logic [1:0] SEL_BAD   = 2'd3;

  logic [NUM_LANES-1:0]            ov, ordy, acc_ch;
  logic [NUM_LANES-1:0][WIDTH-1:0] od;
  logic                            rdy, acc;
`ifdef DEMUX_CNT_EN
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt;
`endif

  assign ordy = {bus.out_ready2, bus.out_ready1, bus.out_ready0};

  // Illegal selects are always taken (and dropped) so the source never stalls on them.
  always_comb begin
    rdy = 1'b1;
    for (int k = 0; k < NUM_LANES; k++)
      if (bus.in_sel == 2'(k)) rdy = !ov[k] | ordy[k];
  end

  assign bus.in_ready = rdy;
  assign acc          = bus.in_valid & rdy;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign acc_ch[g] = acc & (bus.in_sel == 2'(g));
    bit32_demux1to3_reg_lane #(
      .WIDTH (WIDTH)
`ifdef DEMUX_CNT_EN
      , .CNT_W (CNT_W)
`endif
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .acc    (acc_ch[g]),
      .din    (bus.in_data),
      .oready (ordy[g]),
      .ovalid (ov[g]),
      .odata  (od[g])
`ifdef DEMUX_CNT_EN
      , .cnt  (cnt[g])
`endif
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.sel_err <= 1'b0;
    else        bus.sel_err <= acc & (bus.in_sel == SEL_BAD);
  end

  assign bus.out_valid0 = ov[0];
  assign bus.out_valid1 = ov[1];
  assign bus.out_valid2 = ov[2];
  assign bus.out_data0  = od[0];
  assign bus.out_data1  = od[1];
  assign bus.out_data2  = od[2];
`ifdef DEMUX_CNT_EN
  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
  assign cnt2 = cnt[2];
`endif
endmodule

// File: tb/tb_bit32_demux1to3_reg.sv
// Bench for bit32_demux1to3_reg: directed vector table, async-reset and
// counter-wrap sequences, then random traffic against a queue-based model.
module tb_bit32_demux1to3_reg;
  localparam int W = 32;
`ifdef DEMUX_CNT_EN
  localparam int CW = 4;
  logic [CW-1:0] cnt0, cnt1, cnt2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit32_demux1to3_reg_if #(.WIDTH(W)) bus();

  bit32_demux1to3_reg #(
    .WIDTH(W)
`ifdef DEMUX_CNT_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DEMUX_CNT_EN
    , .cnt0 (cnt0), .cnt1 (cnt1), .cnt2 (cnt2)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: each channel is a queue of at most one word.
  logic [W-1:0] mq[3][$];
  logic [W-1:0] mlast[3];
  logic         merr;
  int unsigned  mcnt[3];

  task automatic m_clear();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      mlast[k] = '0;
      mcnt[k] = 0;
    end
    merr = 1'b0;
  endtask

  function automatic bit m_rdy(input logic [1:0] s, input logic [2:0] r);
    if (s == 2'd3) return 1'b1;
    return (mq[s].size() == 0) || r[s];
  endfunction

  task automatic m_step(input logic iv, input logic [1:0] s, input logic [W-1:0] d,
                        input logic [2:0] r);
    bit a;
    a = iv && m_rdy(s, r);
    for (int k = 0; k < 3; k++) begin
      if (r[k] && mq[k].size() != 0) void'(mq[k].pop_front());
      if (a && s == 2'(k)) begin
        mq[k].push_back(d);
        mlast[k] = d;
        mcnt[k]++;
      end
    end
    merr = a && (s == 2'd3);
  endtask

  task automatic drive(input logic iv, input logic [1:0] s, input logic [W-1:0] d,
                       input logic [2:0] r);
    bus.in_valid   = iv;
    bus.in_sel     = s;
    bus.in_data    = d;
    bus.out_ready0 = r[0];
    bus.out_ready1 = r[1];
    bus.out_ready2 = r[2];
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " out_valid0"}, 64'(bus.out_valid0), 64'(mq[0].size() != 0));
    chk({tag, " out_valid1"}, 64'(bus.out_valid1), 64'(mq[1].size() != 0));
    chk({tag, " out_valid2"}, 64'(bus.out_valid2), 64'(mq[2].size() != 0));
    chk({tag, " out_data0"},  64'(bus.out_data0),  64'(mlast[0]));
    chk({tag, " out_data1"},  64'(bus.out_data1),  64'(mlast[1]));
    chk({tag, " out_data2"},  64'(bus.out_data2),  64'(mlast[2]));
    chk({tag, " sel_err"},    64'(bus.sel_err),    64'(merr));
`ifdef DEMUX_CNT_EN
    chk({tag, " cnt0"}, 64'(cnt0), 64'(mcnt[0] % (1 << CW)));
    chk({tag, " cnt1"}, 64'(cnt1), 64'(mcnt[1] % (1 << CW)));
    chk({tag, " cnt2"}, 64'(cnt2), 64'(mcnt[2] % (1 << CW)));
`endif
  endtask

  task automatic do_reset();
    drive(1'b0, 2'd0, '0, 3'b000);
    rst_n = 1'b0;
    m_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       iv;
    logic [1:0] sel;
    logic [31:0] data;
    logic [2:0] ordy;
    logic       rdy;
    logic [2:0] ov;
    logic [31:0] d0, d1, d2;
    logic       err;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 32'd76,      3'b111, 1'b1, 3'b001, 32'd76, 32'd0,     32'd0,       1'b0};
    tbl[1]  = '{1'b1, 2'd1, 32'd90,      3'b111, 1'b1, 3'b010, 32'd76, 32'd90,    32'd0,       1'b0};
    tbl[2]  = '{1'b1, 2'd2, 32'd555,     3'b111, 1'b1, 3'b100, 32'd76, 32'd90,    32'd555,     1'b0};
    tbl[3]  = '{1'b1, 2'd2, 32'd9999999, 3'b111, 1'b1, 3'b100, 32'd76, 32'd90,    32'd9999999, 1'b0};
    tbl[4]  = '{1'b1, 2'd2, 32'd1023,    3'b011, 1'b0, 3'b100, 32'd76, 32'd90,    32'd9999999, 1'b0};
    tbl[5]  = '{1'b1, 2'd2, 32'd1023,    3'b111, 1'b1, 3'b100, 32'd76, 32'd90,    32'd1023,    1'b0};
    tbl[6]  = '{1'b1, 2'd0, 32'd5,       3'b000, 1'b1, 3'b101, 32'd5,  32'd90,    32'd1023,    1'b0};
    tbl[7]  = '{1'b1, 2'd0, 32'd6,       3'b000, 1'b0, 3'b101, 32'd5,  32'd90,    32'd1023,    1'b0};
    tbl[8]  = '{1'b1, 2'd1, 32'd23322,   3'b000, 1'b1, 3'b111, 32'd5,  32'd23322, 32'd1023,    1'b0};
    tbl[9]  = '{1'b1, 2'd3, 32'd42,      3'b000, 1'b1, 3'b111, 32'd5,  32'd23322, 32'd1023,    1'b1};
    tbl[10] = '{1'b0, 2'd1, 32'd7,       3'b000, 1'b0, 3'b111, 32'd5,  32'd23322, 32'd1023,    1'b0};
    tbl[11] = '{1'b0, 2'd3, 32'd7,       3'b111, 1'b1, 3'b000, 32'd5,  32'd23322, 32'd1023,    1'b0};

    do_reset();
    #1;
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    chk_model("reset");

    // Directed table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i].iv, tbl[i].sel, tbl[i].data, tbl[i].ordy);
      #1;
      chk($sformatf("vec%0d in_ready", i), 64'(bus.in_ready), 64'(tbl[i].rdy));
      m_step(tbl[i].iv, tbl[i].sel, tbl[i].data, tbl[i].ordy);
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", i),
          64'({bus.out_valid2, bus.out_valid1, bus.out_valid0}), 64'(tbl[i].ov));
      chk($sformatf("vec%0d out_data0", i), 64'(bus.out_data0), 64'(tbl[i].d0));
      chk($sformatf("vec%0d out_data1", i), 64'(bus.out_data1), 64'(tbl[i].d1));
      chk($sformatf("vec%0d out_data2", i), 64'(bus.out_data2), 64'(tbl[i].d2));
      chk($sformatf("vec%0d sel_err", i),   64'(bus.sel_err),   64'(tbl[i].err));
    end
    chk_model("after table");

    // Async reset between edges while channel 1 holds a word
    @(negedge clk);
    drive(1'b1, 2'd1, 32'hABCD, 3'b000);
    @(posedge clk); #1;
    chk("pre-reset out_valid1", 64'(bus.out_valid1), 64'd1);
    chk("pre-reset out_data1",  64'(bus.out_data1),  64'hABCD);
    drive(1'b0, 2'd1, '0, 3'b000);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid1", 64'(bus.out_valid1), 64'd0);
    chk("async rst out_data1",  64'(bus.out_data1),  64'd0);
    m_clear();
    do_reset();

`ifdef DEMUX_CNT_EN
    // Counter wrap: 17 accepts with CNT_W=4 leaves 1
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(1'b1, 2'd0, W'(i), 3'b001);
      m_step(1'b1, 2'd0, W'(i), 3'b001);
    end
    @(negedge clk);
    drive(1'b0, 2'd0, '0, 3'b001);
    m_step(1'b0, 2'd0, '0, 3'b001);
    @(posedge clk); #1;
    chk("cnt0 wrap", 64'(cnt0), 64'd1);
    chk_model("after wrap");
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic       iv;
      logic [1:0] s;
      logic [W-1:0] d;
      logic [2:0] r;
      @(negedge clk);
      iv = ($urandom_range(0, 3) != 0);
      s  = 2'($urandom_range(0, 3));
      d  = W'($urandom);
      r  = 3'($urandom);
      drive(iv, s, d, r);
      #1;
      chk("rand in_ready", 64'(bus.in_ready), 64'(m_rdy(s, r)));
      m_step(iv, s, d, r);
      @(posedge clk); #1;
      chk_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bit32_demux1to3_reg.md
Name: bit32_demux1to3_reg

Overview:
- Registered 1-to-3 demultiplexer: routes a 32-bit word from one valid/ready source to one of three valid/ready sinks, selected per word by in_sel.
- Inverse of the team's 32-bit 3-to-1 mux, used where one producer (e.g. ALU result bus) fans out to three consumers that can stall independently.
- Each sink has a one-entry output register, so input-to-output latency is 1 cycle and sinks never see combinational paths from the source.

Parameters:
- WIDTH, 32, data width of in_data and every out_data port.
- CNT_W, 16, width of the per-channel transfer counters (used only with DEMUX_CNT_EN).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  source presents a word
- in_ready  output  1  block accepts the word this cycle
- in_sel  input  2  destination: 0,1,2 = channel 0/1/2; 3 = illegal
- in_data  input  WIDTH  source word
- out_valid0/1/2  output  1  channel k register holds a word
- out_ready0/1/2  input  1  sink k takes the word this cycle
- out_data0/1/2  output  WIDTH  channel k registered word
- sel_err  output  1  one-cycle pulse: an illegal-select word was dropped
- cnt0/1/2  output  CNT_W  accepted-word counters (only with DEMUX_CNT_EN)

Behaviour:
- Reset: rst_n low asynchronously clears out_validk=0, out_datak=0, sel_err=0, cntk=0. Applies mid-transfer; any held words are discarded. in_ready is combinational and depends only on state and inputs.
- Per-channel state, EMPTY (out_validk=0) / FULL (out_validk=1):
  - EMPTY -> FULL on accept to k.
  - FULL -> EMPTY on out_readyk with no accept to k.
  - FULL -> FULL on out_readyk plus accept to k in the same cycle. out_datak takes the new word with no bubble.
  - FULL with out_readyk=0 holds data and valid stable.
- in_ready: for in_sel=k in {0,1,2}, in_ready = !out_validk | out_readyk. For in_sel=3, in_ready=1.
- Accept occurs when in_valid & in_ready. The word appears on out_datak with out_validk=1 on the next rising edge.
- Illegal select: an accepted in_sel=3 word is dropped. No channel changes. sel_err=1 for exactly the following cycle, otherwise 0.
- in_sel and in_data are sampled only on accept. When in_valid=0, in_ready still reflects the current in_sel. No state changes.
- Channels are independent: a stalled channel never blocks words to other channels.
- Output register holds at most one word; no reordering within a channel.
- out_datak is unchanged while out_validk=0 after a drain; it retains its last value.

Optional Feature:
- Macro DEMUX_CNT_EN.
- Defined: cnt0/1/2 ports exist. cntk increments by 1 on each accept to channel k and wraps from 2^CNT_W-1 to 0. Illegal-select words are not counted.
- Undefined: cnt ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset then in_valid=1, in_sel=0, in_data=76, out_ready0=1 -> in_ready=1; next cycle out_valid0=1, out_data0=76; other valids stay 0.
- Words 90 to sel=1 then 555 to sel=2 on consecutive cycles, all sinks ready -> out_data1=90 and out_data2=555, each 1 cycle after its accept.
- Fill channel 2 with 9999999 and hold out_ready2=0, then present 1023 to sel=2 -> in_ready=0; out_data2 stays 9999999. Then raise out_ready2 -> 1023 is accepted the same cycle and appears next cycle with no gap.
- Channel 0 stalled and full, then send 23322 to sel=1 -> accepted immediately; out_data1=23322 next cycle; channel 0 unchanged.
- in_sel=3, in_data=42, in_valid=1 -> in_ready=1; sel_err=1 for one cycle; no out_valid asserts; counters unchanged with DEMUX_CNT_EN.
- Channel 1 full, assert rst_n=0 between clock edges -> out_valid1=0 and out_data1=0 immediately. With DEMUX_CNT_EN and CNT_W=4, 17 accepts to ch0 -> cnt0=1.
